// File: rtl/lsu_mem_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lsu_mem_port                                                    |
// | Brief    : Load/store unit: EA generation, lane-aligned bus request,       |
// |            load extraction. Optional macro LSU_MISALIGN_TRAP_EN traps      |
// |            misaligned accesses instead of aligning them down.              |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module lsu_mem_port #(
    parameter int XLEN  = 32,
    parameter int IMM_W = 12,
    parameter int RD_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [IMM_W-1:0]  imm,
    input  logic [XLEN-1:0]   op0,
    input  logic [XLEN-1:0]   op1,
    input  logic [RD_W-1:0]   rd_in,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              exc_valid,
    output logic [3:0]        exc_cause,
    output logic [XLEN-1:0]   exc_tval
);

    localparam int c_NB    = XLEN / 8;
    localparam int c_OFF_W = $clog2(c_NB);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;
    localparam logic [1:0] c_EXC  = 2'd3;

    logic [1:0]         r_state;
    logic [2:0]         r_funct3;
    logic [RD_W-1:0]    r_rd;
    logic [c_OFF_W-1:0] r_off;

    logic               r_mem_req_valid;
    logic               r_mem_we;
    logic [XLEN-1:0]    r_mem_addr;
    logic [XLEN-1:0]    r_mem_wdata;
    logic [c_NB-1:0]    r_mem_be;
    logic               r_wb_valid;
    logic [RD_W-1:0]    r_wb_rd;
    logic [XLEN-1:0]    r_wb_data;
    logic               r_exc_valid;
    logic [3:0]         r_exc_cause;
    logic [XLEN-1:0]    r_exc_tval;

    logic [XLEN-1:0]    w_ea;
    int                 w_size;
    logic [c_OFF_W-1:0] w_lowmask;
    logic [c_OFF_W-1:0] w_off;
    logic               w_legal;
    logic               w_trap_mis;
    logic [c_NB-1:0]    w_be;
    logic [XLEN-1:0]    w_wdata;
    logic [XLEN-1:0]    w_shift;
    logic               w_sign;
    int                 w_bits;
    logic [XLEN-1:0]    w_ld;

    // Request-side decode, evaluated on the incoming operands in IDLE.
    always_comb begin
        w_ea      = op0 + {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
        w_size    = 1 << funct3[1:0];
        w_lowmask = c_OFF_W'(w_size - 1);
        w_off     = w_ea[c_OFF_W-1:0] & ~w_lowmask;
        case (funct3)
            3'd0, 3'd1, 3'd2: w_legal = 1'b1;
            3'd3:             w_legal = (XLEN == 64);
            3'd4, 3'd5:       w_legal = !is_store;
            3'd6:             w_legal = !is_store && (XLEN == 64);
            default:          w_legal = 1'b0;
        endcase
        w_be    = '0;
        w_wdata = '0;
        for (int i = 0; i < c_NB; i++) begin
            w_be[i]          = (i >= int'(w_off)) && (i < int'(w_off) + w_size);
            w_wdata[8*i +: 8] = op1[8*(i & (w_size - 1)) +: 8];
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap_mis = |(w_ea[c_OFF_W-1:0] & w_lowmask);
`else
    assign w_trap_mis = 1'b0;
`endif

    // Response-side extraction from the latched lane offset and width.
    always_comb begin
        w_shift = mem_rdata >> {r_off, 3'b000};
        case (r_funct3[1:0])
            2'd0:    w_sign = w_shift[7];
            2'd1:    w_sign = w_shift[15];
            2'd2:    w_sign = w_shift[31];
            default: w_sign = w_shift[XLEN-1];
        endcase
        w_bits = 8 << r_funct3[1:0];
        w_ld   = '0;
        for (int j = 0; j < XLEN; j++)
            w_ld[j] = (j < w_bits) ? w_shift[j] : (w_sign & ~r_funct3[2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_IDLE;
            r_funct3        <= '0;
            r_rd            <= '0;
            r_off           <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_mem_be        <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_rd         <= '0;
            r_wb_data       <= '0;
            r_exc_valid     <= 1'b0;
            r_exc_cause     <= '0;
            r_exc_tval      <= '0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_exc_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_funct3 <= funct3;
                        r_rd     <= rd_in;
                        r_off    <= w_off;
                        if (!w_legal || w_trap_mis) begin
                            r_exc_valid <= 1'b1;
                            r_exc_cause <= !w_legal ? 4'd2 : (is_store ? 4'd6 : 4'd4);
                            r_exc_tval  <= w_ea;
                            r_state     <= c_EXC;
                        end else begin
                            r_mem_req_valid <= 1'b1;
                            r_mem_we        <= is_store;
                            r_mem_addr      <= {w_ea[XLEN-1:c_OFF_W], {c_OFF_W{1'b0}}};
                            r_mem_be        <= w_be;
                            r_mem_wdata     <= w_wdata;
                            r_state         <= c_REQ;
                        end
                    end
                end
                c_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= r_mem_we ? c_IDLE : c_RESP;
                    end
                end
                c_RESP: begin
                    if (mem_rsp_valid) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= w_ld;
                        r_state    <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign req_ready     = (r_state == c_IDLE) && !rst;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_be        = r_mem_be;
    assign wb_valid      = r_wb_valid;
    assign wb_rd         = r_wb_rd;
    assign wb_data       = r_wb_data;
    assign exc_valid     = r_exc_valid;
    assign exc_cause     = r_exc_cause;
    assign exc_tval      = r_exc_tval;

endmodule
`default_nettype wire
